// File: rtl/adder_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : adder_share_arbiter
// Description : Round-robin arbiter that time-shares one registered
//               (N+1)-bit adder among NUM_REQ requesters; results are
//               returned tagged with the owning requester index.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_share_arbiter #(
  parameter int N       = 10,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*N-1:0]   a_bus,
  input  logic [NUM_REQ*N-1:0]   b_bus,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic [N:0]             sum_out,
  output logic                   sum_valid,
  output logic [ID_W-1:0]        sum_id
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // After reset the pointer sits on the last index so requester 0 wins first
  localparam logic [ID_W-1:0] c_PTR_RST = ID_W'(NUM_REQ - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] r_id;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;

  logic            w_win_found;
  logic [ID_W-1:0] w_win_id;
  logic [ID_W-1:0] w_cand;
  logic [N-1:0]    w_win_a;
  logic [N-1:0]    w_win_b;

  // Round-robin search starting one past the last winner, wrapping
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = '0;
    w_cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_win_found && req[w_cand]) begin
        w_win_found = 1'b1;
        w_win_id    = w_cand;
      end
    end
  end

  always_comb begin
    w_win_a = '0;
    w_win_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win_id == ID_W'(i)) begin
        w_win_a = a_bus[i*N +: N];
        w_win_b = b_bus[i*N +: N];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_win_found) w_state_nxt = ST_ADD;
      ST_ADD:  w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= c_PTR_RST;
      r_id    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      sum_out <= '0;
      sum_id  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_win_found) begin
        r_a   <= w_win_a;
        r_b   <= w_win_b;
        r_id  <= w_win_id;
        r_ptr <= w_win_id;
      end
      if (r_state == ST_ADD) begin
        sum_out <= {1'b0, r_a} + {1'b0, r_b};
        sum_id  <= r_id;
      end
    end
  end

  // Handshake outputs are pure state decodes, so reset clears them at once
  always_comb begin
    grant = '0;
    if (r_state == ST_ADD) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        grant[i] = (r_id == ID_W'(i));
      end
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign sum_valid = (r_state == ST_RESP);

endmodule
`default_nettype wire

// File: tb/tb_adder_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_share_arbiter
// Description : Self-checking bench: vector table, corner sequences and a
//               randomized run against a timestamp-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_share_arbiter;

  localparam int N       = 10;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [NUM_REQ-1:0]   req = '0;
  logic [NUM_REQ*N-1:0] a_bus;
  logic [NUM_REQ*N-1:0] b_bus;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;
  logic [N:0]           sum_out;
  logic                 sum_valid;
  logic [ID_W-1:0]      sum_id;

  logic [N-1:0] a_op [NUM_REQ];
  logic [N-1:0] b_op [NUM_REQ];

  int errors = 0;
  int checks = 0;

  adder_share_arbiter #(.N(N), .NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .a_bus     (a_bus),
    .b_bus     (b_bus),
    .grant     (grant),
    .busy      (busy),
    .sum_out   (sum_out),
    .sum_valid (sum_valid),
    .sum_id    (sum_id)
  );

  always #5 clk = ~clk;

  always_comb begin
    a_bus = '0;
    b_bus = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      a_bus[i*N +: N] = a_op[i];
      b_bus[i*N +: N] = b_op[i];
    end
  end

  typedef struct {
    logic [NUM_REQ-1:0] vreq;
    int                 slot;
    int                 a;
    int                 b;
    int                 exp_sum;
  } vec_t;

  vec_t vecs [6];

  // Reference model: transaction timestamps in edges since reset release
  int m_edge, m_free, m_gedge, m_ptr, m_win, m_pend_sum, m_sum, m_id;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      a_op[i] = N'($urandom_range(0, 1023));
      b_op[i] = N'($urandom_range(0, 1023));
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    tick();
    tick();
    reset_n = 1'b1;
    m_edge = 0; m_free = 0; m_gedge = -10; m_ptr = NUM_REQ - 1;
    m_win = 0; m_pend_sum = 0; m_sum = 0; m_id = 0;
  endtask

  task automatic model_step_and_check(input int cyc);
    int x;
    bit found;
    logic [NUM_REQ-1:0] eg;
    logic eb, ev;
    x = m_edge;
    if (x == m_gedge + 1) begin
      m_sum = m_pend_sum;
      m_id  = m_win;
    end
    if (x >= m_free && req != '0) begin
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (!found && req[(m_ptr + k) % NUM_REQ]) begin
          found = 1'b1;
          m_win = (m_ptr + k) % NUM_REQ;
        end
      end
      m_pend_sum = int'(a_op[m_win]) + int'(b_op[m_win]);
      m_ptr   = m_win;
      m_gedge = x;
      m_free  = x + 3;
    end
    eg = '0;
    if (x == m_gedge) eg[m_win] = 1'b1;
    eb = (x == m_gedge) || (x == m_gedge + 1);
    ev = (x == m_gedge + 1);
    m_edge++;
    checks++;
    if (grant !== eg || busy !== eb || sum_valid !== ev ||
        int'(sum_out) != m_sum || int'(sum_id) != m_id) begin
      errors++;
      $display("FAIL rand cyc %0d: grant=%b busy=%b valid=%b sum=%0d id=%0d, expected grant=%b busy=%b valid=%b sum=%0d id=%0d",
               cyc, grant, busy, sum_valid, sum_out, sum_id, eg, eb, ev, m_sum, m_id);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int order [5];
    int sums  [5];
    int nres, ngr, last_cyc;
    logic [NUM_REQ-1:0] eg;

    vecs[0] = '{4'b0010, 1, 1,    99,   100};
    vecs[1] = '{4'b1010, 3, 1023, 1023, 2046};
    vecs[2] = '{4'b0011, 0, 1023, 1,    1024};
    vecs[3] = '{4'b0011, 1, 512,  511,  1023};
    vecs[4] = '{4'b0001, 0, 7,    8,    15};
    vecs[5] = '{4'b1000, 3, 0,    0,    0};

    // Reset values with random activity on the inputs
    reset_n = 1'b0;
    req = NUM_REQ'($urandom_range(1, 15));
    rand_ops();
    tick(); tick(); tick();
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(sum_valid), 0);
    chk("rst_sum", int'(sum_out), 0);
    chk("rst_id", int'(sum_id), 0);
    req = '0;
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("idle_after_rst", int'({grant, busy, sum_valid}), 0);
    end

    // Single transactions: pointer walk, skip, wrap and max operands
    for (int v = 0; v < 6; v++) begin
      req = vecs[v].vreq;
      rand_ops();
      a_op[vecs[v].slot] = N'(vecs[v].a);
      b_op[vecs[v].slot] = N'(vecs[v].b);
      eg = '0;
      eg[vecs[v].slot] = 1'b1;
      tick();
      chk($sformatf("v%0d_grant", v), int'(grant), int'(eg));
      chk($sformatf("v%0d_busy_add", v), int'(busy), 1);
      chk($sformatf("v%0d_novalid_add", v), int'(sum_valid), 0);
      req = '0;
      rand_ops();
      tick();
      chk($sformatf("v%0d_valid", v), int'(sum_valid), 1);
      chk($sformatf("v%0d_sum", v), int'(sum_out), vecs[v].exp_sum);
      chk($sformatf("v%0d_id", v), int'(sum_id), vecs[v].slot);
      chk($sformatf("v%0d_grant_resp", v), int'(grant), 0);
      tick();
      chk($sformatf("v%0d_idle", v), int'({busy, sum_valid}), 0);
      chk($sformatf("v%0d_sum_hold", v), int'(sum_out), vecs[v].exp_sum);
    end

    // Continuous round-robin with all requesters active
    do_reset();
    order = '{0, 1, 2, 3, 0};
    sums  = '{0, 80, 147, 1023, 0};
    a_op[0] = 10'd0;   b_op[0] = 10'd0;
    a_op[1] = 10'd33;  b_op[1] = 10'd47;
    a_op[2] = 10'd100; b_op[2] = 10'd47;
    a_op[3] = 10'd512; b_op[3] = 10'd511;
    req = 4'b1111;
    nres = 0; ngr = 0; last_cyc = 0;
    for (int c = 1; c <= 20 && nres < 5; c++) begin
      tick();
      if (grant != '0 && ngr < 5) begin
        eg = '0;
        eg[order[ngr]] = 1'b1;
        chk($sformatf("rr_grant%0d", ngr), int'(grant), int'(eg));
        ngr++;
      end
      if (sum_valid) begin
        chk($sformatf("rr_id%0d", nres), int'(sum_id), order[nres]);
        chk($sformatf("rr_sum%0d", nres), int'(sum_out), sums[nres]);
        if (nres > 0) chk($sformatf("rr_gap%0d", nres), c - last_cyc, 3);
        last_cyc = c;
        nres++;
      end
    end
    chk("rr_results", nres, 5);
    req = '0;
    tick(); tick(); tick();

    // Reset during ADD discards the operation and restores the pointer
    do_reset();
    rand_ops();
    req = 4'b0110;
    tick();
    chk("mid_grant_before", int'(grant), 4'b0010);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_outputs", int'({grant, busy, sum_valid}), 0);
    chk("mid_rst_sum", int'(sum_out), 0);
    req = '0;
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("mid_no_valid", int'({busy, sum_valid}), 0);
    end
    req = 4'b0101;
    tick();
    chk("mid_ptr_reset_grant", int'(grant), 4'b0001);
    req = '0;
    tick(); tick(); tick();

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = '0;
      else req = NUM_REQ'($urandom_range(0, 15));
      rand_ops();
      tick();
      model_step_and_check(c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
